adc_sweep_scheduler: RTL and testbench
======================================

# adc_sweep_scheduler

Sequences the AVR ADC channel select across a set of enabled channels in round-robin order. Drives the `channel` input of the AVR interface and consumes its `new_sample`/`sample`/`sample_channel` stream, filtering out samples from other channels. Emits one result per visited channel and marks sweep completion. Per-sample timeouts keep a silent channel from stalling the sweep.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 50000: maximum number of `clk` cycles to wait for one matching sample; must be ≥ 2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a sweep; ignored while `busy`=1.
- `continuous` in 1: when 1, the block starts a new sweep automatically after each completed sweep.
- `ch_mask` in 16: enabled channels (bit i enables channel i); latched at the start of each sweep.
- `channel` out 4: channel select, connected to the AVR interface `channel` input.
- `new_sample` in 1: pulse from the AVR interface indicating a new sample.
- `sample` in 10: sample value from the AVR interface.
- `sample_channel` in 4: channel the sample was taken on.
- `busy` out 1: high whenever the state is not IDLE.
- `out_valid` out 1: one-cycle result strobe.
- `out_sample` out 10: result value; held until the next `out_valid`.
- `out_channel` out 4: channel of the result; held until the next `out_valid`.
- `timeout` out 1: one-cycle pulse when the current channel is abandoned.
- `sweep_done` out 1: one-cycle pulse at the end of a sweep.
- `drop_count` out 8: saturating count of discarded samples whose channel did not match.

## Operation
- **States:** IDLE, WAIT, ADVANCE.
- **IDLE → WAIT:** taken when (`start` or `continuous`) and `ch_mask` ≠ 0. On this transition:
  - `mask_q` ← `ch_mask`.
  - `channel` ← lowest set bit of `ch_mask`.
  - Timer and accumulator are cleared.
- **IDLE with `ch_mask` = 0:** `start` is ignored; no pulses are generated.
- **WAIT, matching sample** (`new_sample` and `sample_channel` = `channel`):
  - The sample is accumulated and the timer is cleared.
  - When the required sample count is reached:
    - `out_sample` and `out_channel` are loaded.
    - `out_valid` is pulsed.
    - The state moves to ADVANCE.
- **WAIT, non-matching sample:** the sample is discarded and `drop_count` increments, saturating at 255. This covers stale samples from the previous channel after a switch.
- **WAIT, timer expiry** (timer = `TIMEOUT_CYCLES`−1 with no matching sample in that cycle):
  - `timeout` is pulsed; no `out_valid` is generated.
  - Partial accumulation is discarded.
  - The state moves to ADVANCE.
- **Simultaneous events in WAIT:** a matching sample in the same cycle as timer expiry takes priority over the timeout.
- **ADVANCE, next channel:** the next channel is the lowest set bit of `mask_q` strictly above `channel`.
  - If such a bit exists: `channel` ← that channel, then return to WAIT with timer and accumulator cleared.
  - If none exists (wrap-around): pulse `sweep_done`.
    - If `continuous`=1 and `ch_mask` ≠ 0: re-latch `mask_q` and `channel` ← lowest set bit, then go to WAIT.
    - Otherwise go to IDLE.
- **Single-channel mask:** each sweep visits exactly one channel, and `sweep_done` follows every result or timeout.
- **`continuous` deasserted mid-sweep:** the current sweep completes, then the block goes to IDLE.
- **`ch_mask` changed mid-sweep:** the change has no effect until the next sweep latch.
- **`timeout`, `out_valid` and `sweep_done` pulse timing:** each is high for exactly one cycle.

## Timing
- **Reset values** (all outputs registered, so these appear one edge after `rst`=0):
  - `channel`=0, `busy`=0, `out_valid`=0, `out_sample`=0, `out_channel`=0, `timeout`=0, `sweep_done`=0, `drop_count`=0.
  - State = IDLE; `mask_q`=0.
- **Start latency:** `start` sampled at edge N → `channel` and `busy`=1 are valid after edge N.
- **Result latency:** final matching sample at edge K → `out_valid` high in the cycle after K. `channel` changes at edge K+1, or `sweep_done` pulses after K+1.
- **Timeout:** `timeout` asserts `TIMEOUT_CYCLES` cycles after entry to WAIT or after the last matching sample.
- **Timer width:** `$clog2(TIMEOUT_CYCLES)` bits.
- **Overhead:** minimum of one ADVANCE cycle between consecutive channels.
- **Reset mid-operation:** `rst`=0 returns the block to IDLE at the next edge, with every output at its reset value and any partial sweep abandoned.

## Configuration
- **`ADC_SCHED_AVG_EN` defined:** each channel requires 4 matching samples.
  - Samples are summed in a 12-bit accumulator.
  - `out_sample` = sum[11:2], truncating.
  - A timeout discards the partial sum.
- **`ADC_SCHED_AVG_EN` undefined:** one matching sample per channel; `out_sample` = `sample`. The accumulator logic is not built.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles during an active WAIT → every output at its reset value and `busy`=0 one edge later.
- **Two-channel sweep:** `ch_mask`=16'h0012, pulse `start`, return matching samples 10'h155 on ch1 and 10'h2AA on ch4 → `out_valid`×2 (1/155, then 4/2AA), `sweep_done` one cycle after the ch4 ADVANCE, then IDLE. (Without `ADC_SCHED_AVG_EN`.)
- **Filtering:** on ch4, send a sample tagged ch1 before the ch4 sample → `drop_count`=1, only the ch4 result emitted. Then inject 300 mismatches → `drop_count`=255.
- **Timeout:** `TIMEOUT_CYCLES`=20, mask 16'h0005, ch0 silent → `timeout` pulses exactly 20 cycles after WAIT entry, and `channel`=2 follows.
- **Continuous mode:** `continuous`=1, mask 16'h8001, change mask to 16'h0002 mid-sweep → the first sweep visits 0 then 15 (wrap-around), the next sweep visits 1 only. Clearing `continuous` stops the block after that sweep.
- **Averaging:** with `ADC_SCHED_AVG_EN`, ch3 samples 100, 101, 102, 104 → single `out_valid` with `out_sample`=101.

Source files
------------

// File: rtl/adc_sweep_scheduler.sv
// adc_sweep_scheduler: visits the enabled ADC channels in round-robin order.
// It drives the AVR channel select, filters the returned sample stream by
// channel, and emits one result per visited channel. A per-channel timeout
// skips a channel that never answers.
// Optional build macro: ADC_SCHED_AVG_EN averages 4 samples per channel.
module adc_sweep_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic [15:0] ch_mask,
  output logic [3:0]  channel,
  input  logic        new_sample,
  input  logic [9:0]  sample,
  input  logic [3:0]  sample_channel,
  output logic        busy,
  output logic        out_valid,
  output logic [9:0]  out_sample,
  output logic [3:0]  out_channel,
  output logic        timeout,
  output logic        sweep_done,
  output logic [7:0]  drop_count
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ADVANCE} state_t;

  state_t        r_state;
  logic [15:0]   r_mask;
  logic [TW-1:0] r_timer;

  logic          w_match;
  logic          w_last;
  logic [9:0]    w_result;
  logic [4:0]    w_next;
  logic [3:0]    w_first;

  // Lowest set bit of a mask (caller guarantees the mask is non-zero).
  function automatic logic [3:0] lowest_bit(input logic [15:0] m);
    lowest_bit = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) lowest_bit = 4'(i);
    end
  endfunction

  // {found, index} of the lowest set bit strictly above c.
  function automatic logic [4:0] next_above(input logic [15:0] m, input logic [3:0] c);
    next_above = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (i > int'(c))) next_above = {1'b1, 4'(i)};
    end
  endfunction

  assign w_match = new_sample && (sample_channel == channel);
  assign w_next  = next_above(r_mask, channel);
  assign w_first = lowest_bit(ch_mask);

`ifdef ADC_SCHED_AVG_EN
  logic [11:0] r_acc;
  logic [1:0]  r_cnt;
  logic [11:0] w_sum;

  assign w_sum    = r_acc + 12'(sample);
  assign w_last   = (r_cnt == 2'd3);
  assign w_result = w_sum[11:2];

  // Accumulate matching samples; anything outside WAIT (including the cycle
  // after a timeout) clears the partial sum.
  always_ff @(posedge clk) begin
    if (!rst || (r_state != S_WAIT)) begin
      r_acc <= 12'd0;
      r_cnt <= 2'd0;
    end else if (w_match) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 2'd1;
    end
  end
`else
  assign w_last   = 1'b1;
  assign w_result = sample;
`endif

  // Sweep state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mask      <= 16'd0;
      r_timer     <= '0;
      channel     <= 4'd0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_sample  <= 10'd0;
      out_channel <= 4'd0;
      timeout     <= 1'b0;
      sweep_done  <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      out_valid  <= 1'b0;
      timeout    <= 1'b0;
      sweep_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if ((start || continuous) && (ch_mask != 16'd0)) begin
            r_mask  <= ch_mask;
            channel <= w_first;
            r_timer <= '0;
            busy    <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_match) begin
            r_timer <= '0;
            if (w_last) begin
              out_valid   <= 1'b1;
              out_sample  <= w_result;
              out_channel <= channel;
              r_state     <= S_ADVANCE;
            end
          end else begin
            if (new_sample && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
            if (r_timer == TIMER_LAST) begin
              timeout <= 1'b1;
              r_state <= S_ADVANCE;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        S_ADVANCE: begin
          r_timer <= '0;
          if (w_next[4]) begin
            channel <= w_next[3:0];
            r_state <= S_WAIT;
          end else begin
            sweep_done <= 1'b1;
            if (continuous && (ch_mask != 16'd0)) begin
              r_mask  <= ch_mask;
              channel <= w_first;
              r_state <= S_WAIT;
            end else begin
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sweep_scheduler.sv
// Directed bench for adc_sweep_scheduler with TIMEOUT_CYCLES = 20.
module tb_adc_sweep_scheduler;

`ifdef ADC_SCHED_AVG_EN
  localparam int NS = 4;
`else
  localparam int NS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, start, continuous, new_sample;
  logic [15:0] ch_mask;
  logic [9:0]  sample;
  logic [3:0]  sample_channel;
  logic [3:0]  channel, out_channel;
  logic        busy, out_valid, timeout, sweep_done;
  logic [9:0]  out_sample;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;

  adc_sweep_scheduler #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .channel(channel), .new_sample(new_sample),
    .sample(sample), .sample_channel(sample_channel), .busy(busy),
    .out_valid(out_valid), .out_sample(out_sample), .out_channel(out_channel),
    .timeout(timeout), .sweep_done(sweep_done), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Deliver the number of matching samples one channel needs.
  task automatic send_match(input logic [3:0] ch, input logic [9:0] val);
    for (int i = 0; i < NS; i++) begin
      new_sample = 1'b1; sample_channel = ch; sample = val;
      tick();
    end
    new_sample = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; start = 1'b0; continuous = 1'b0; new_sample = 1'b0;
    ch_mask = 16'd0; sample = 10'd0; sample_channel = 4'd0;

    // Power-on reset
    tick(); tick(); tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_channel", 32'(channel), 32'd0);
    check("rst_outs", {out_valid, timeout, sweep_done, out_sample, out_channel, drop_count}, 32'd0);
    rst = 1'b1;
    tick();

    // Empty mask: start ignored
    start = 1'b1; tick(); start = 1'b0;
    check("mask0_busy", 32'(busy), 32'd0);
    tick();
    check("mask0_pulses", {31'd0, sweep_done}, 32'd0);

    // Two-channel sweep with a stale sample on ch4
    ch_mask = 16'h0012; start = 1'b1; tick(); start = 1'b0;
    check("sw_busy", 32'(busy), 32'd1);
    check("sw_ch_first", 32'(channel), 32'd1);
    ch_mask = 16'h0000;
    send_match(4'd1, 10'h155);
    check("sw_res1", {17'd0, out_valid, out_channel, out_sample}, {17'd0, 1'b1, 4'd1, 10'h155});
    tick();
    check("sw_valid_pulse", 32'(out_valid), 32'd0);
    check("sw_ch_second", 32'(channel), 32'd4);
    new_sample = 1'b1; sample_channel = 4'd1; sample = 10'h3C3; tick(); new_sample = 1'b0;
    check("flt_drop1", 32'(drop_count), 32'd1);
    check("flt_no_valid", 32'(out_valid), 32'd0);
    send_match(4'd4, 10'h2AA);
    check("sw_res2", {17'd0, out_valid, out_channel, out_sample}, {17'd0, 1'b1, 4'd4, 10'h2AA});
    tick();
    check("sw_done", {30'd0, sweep_done, busy}, {30'd0, 1'b1, 1'b0});
    tick();
    check("sw_done_pulse", 32'(sweep_done), 32'd0);
    check("sw_held", {out_channel, out_sample}, {4'd4, 10'h2AA});

    // Timeout on silent ch0, then ch2
    ch_mask = 16'h0005; start = 1'b1; tick(); start = 1'b0;
    check("to_ch0", 32'(channel), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      if (timeout) seen = 1'b1;
    end
    check("to_early", 32'(seen), 32'd0);
    tick();
    check("to_pulse", {30'd0, timeout, out_valid}, {30'd0, 1'b1, 1'b0});
    tick();
    check("to_next", {27'd0, timeout, channel}, {27'd0, 1'b0, 4'd2});
    send_match(4'd2, 10'h3FF);
    check("to_res", {17'd0, out_valid, out_channel, out_sample}, {17'd0, 1'b1, 4'd2, 10'h3FF});
    tick();
    check("to_done", 32'(sweep_done), 32'd1);

    // Continuous mode, mask change mid-sweep, wrap-around
    ch_mask = 16'h8001; continuous = 1'b1; tick();
    check("ct_ch0", {31'd0, busy}, 32'd1);
    check("ct_ch0_sel", 32'(channel), 32'd0);
    ch_mask = 16'h0002;
    send_match(4'd0, 10'h011);
    check("ct_res0", {17'd0, out_valid, out_channel, out_sample}, {17'd0, 1'b1, 4'd0, 10'h011});
    tick();
    check("ct_ch15", 32'(channel), 32'd15);
    send_match(4'd15, 10'h0FF);
    check("ct_res15", {17'd0, out_valid, out_channel, out_sample}, {17'd0, 1'b1, 4'd15, 10'h0FF});
    tick();
    check("ct_wrap", {27'd0, sweep_done, channel}, {27'd0, 1'b1, 4'd1});
    continuous = 1'b0;
    send_match(4'd1, 10'h001);
    check("ct_res1", {17'd0, out_valid, out_channel, out_sample}, {17'd0, 1'b1, 4'd1, 10'h001});
    tick();
    check("ct_stop", {30'd0, sweep_done, busy}, {30'd0, 1'b1, 1'b0});
    tick();
    check("ct_stays_idle", 32'(busy), 32'd0);

    // Drop counter saturation across repeated single-channel sweeps
    ch_mask = 16'h0001; continuous = 1'b1;
    new_sample = 1'b1; sample_channel = 4'd5; sample = 10'h0AA;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (drop_count == 8'd0) seen = 1'b1;
    end
    new_sample = 1'b0;
    check("sat_255", 32'(drop_count), 32'd255);
    check("sat_no_wrap", 32'(seen), 32'd0);
    continuous = 1'b0;
    wait_idle("sat_idle");

    // Reset in the middle of WAIT
    ch_mask = 16'h0010; start = 1'b1; tick(); start = 1'b0;
    check("mr_ch4", 32'(channel), 32'd4);
    rst = 1'b0;
    tick();
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_outs", {channel, out_sample, out_channel, drop_count}, 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("mr_after", {30'd0, busy, timeout}, 32'd0);

`ifdef ADC_SCHED_AVG_EN
    // Averaging of four ch3 samples
    ch_mask = 16'h0008; start = 1'b1; tick(); start = 1'b0;
    new_sample = 1'b1; sample_channel = 4'd3;
    sample = 10'd100; tick();
    sample = 10'd101; tick();
    sample = 10'd102; tick();
    check("avg_partial", 32'(out_valid), 32'd0);
    sample = 10'd104; tick();
    new_sample = 1'b0;
    check("avg_res", {17'd0, out_valid, out_channel, out_sample}, {17'd0, 1'b1, 4'd3, 10'd101});
    tick();
    check("avg_done", 32'(sweep_done), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
